// File: rtl/cnn_fc_pkg.sv
// Shared widths, signed data types and sequencer state encoding for the fully-connected stage.
package cnn_fc_pkg;

  localparam int ACT_W = 30;
  localparam int WGT_W = 9;
  localparam int ACC_W = 48;

  typedef logic signed [ACT_W-1:0] act_t;
  typedef logic signed [WGT_W-1:0] wgt_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_BIAS,
    ST_OUT,
    ST_FIN
  } fc_state_t;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_layer_seq_if.sv
// Result port of the FC sequencer: one (neuron index, signed sum) per valid/ready handshake.
interface fc_layer_seq_if
  import cnn_fc_pkg::*;
#(
  parameter int IDX_W = 4
) ();

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  acc_t             out_data;

  modport master (output out_valid, output out_idx, output out_data, input out_ready);
  modport slave  (input out_valid, input out_idx, input out_data, output out_ready);

endinterface

// File: rtl/fc_mac.sv
// Registered signed multiply-accumulate; clear has priority over en, sums wrap in ACC_W bits.
module fc_mac
  import cnn_fc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  act_t a,
  input  wgt_t b,
  output acc_t acc
);

  localparam int PROD_W = ACT_W + WGT_W;

  logic signed [PROD_W-1:0] prod;
  acc_t                     acc_reg;
  acc_t                     acc_next;

  always_comb begin
    prod     = PROD_W'(a) * PROD_W'(b);
    acc_next = acc_reg;
    if (clear) begin
      acc_next = '0;
    end else if (en) begin
      acc_next = acc_reg + acc_t'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/fc_layer_seq.sv
// Serial FC-layer sequencer: one MAC walks N_IN activations/weights per neuron, adds bias, emits result.
// Build option FC_RELU_EN: clamp negative neuron sums to zero before they are presented.
module fc_layer_seq
  import cnn_fc_pkg::*;
#(
  parameter int N_IN   = 3136,
  parameter int N_OUT  = 10,
  parameter int RD_LAT = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           act_rd_en,
  output logic [idx_w(N_IN)-1:0]         act_addr,
  input  act_t                           act_data,
  output logic                           w_rd_en,
  output logic [idx_w(N_IN*N_OUT)-1:0]   w_addr,
  input  wgt_t                           w_data,
  output logic [idx_w(N_OUT)-1:0]        b_addr,
  input  wgt_t                           b_data,
  fc_layer_seq_if.master                 out_if
);

  localparam int K_W  = idx_w(N_IN);
  localparam int WA_W = idx_w(N_IN * N_OUT);
  localparam int N_W  = idx_w(N_OUT);

  localparam logic [K_W-1:0] K_LAST   = K_W'(N_IN - 1);
  localparam logic [N_W-1:0] N_LAST   = N_W'(N_OUT - 1);
  localparam logic [1:0]     LAT_LAST = 2'(RD_LAT - 1);

  fc_state_t         state_reg, state_next;
  logic [K_W-1:0]    k_reg;
  logic [WA_W-1:0]   w_addr_reg;
  logic [N_W-1:0]    neuron_reg;
  logic [1:0]        lat_reg;
  logic [RD_LAT-1:0] vld_reg, vld_next;

  logic              out_valid_reg;
  logic [N_W-1:0]    out_idx_reg;
  acc_t              out_data_reg;

  logic              mac_clear;
  logic              mac_en;
  logic              accept;
  logic              last_neuron;
  acc_t              mac_acc;
  acc_t              sum;

  always_comb begin
    state_next  = state_reg;
    mac_clear   = 1'b0;
    accept      = (state_reg == ST_OUT) && out_if.out_ready;
    last_neuron = (neuron_reg == N_LAST);
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_ISSUE;
          mac_clear  = 1'b1;
        end
      end
      ST_ISSUE: if (k_reg == K_LAST) state_next = ST_DRAIN;
      ST_DRAIN: if (lat_reg == LAT_LAST) state_next = ST_BIAS;
      ST_BIAS:  state_next = ST_OUT;
      ST_OUT: begin
        if (accept) begin
          if (last_neuron) begin
            state_next = ST_FIN;
          end else begin
            state_next = ST_ISSUE;
            mac_clear  = 1'b1;
          end
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Read-valid pipe: stage RD_LAT-1 marks the cycle the RAM data for a read is on the bus.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_vld
      if (gi == 0) begin : g_head
        assign vld_next[gi] = act_rd_en;
      end else begin : g_tail
        assign vld_next[gi] = vld_reg[gi-1];
      end
    end
  endgenerate

  assign mac_en = vld_reg[RD_LAT-1];

  always_comb begin
    sum = mac_acc + acc_t'(b_data);
`ifdef FC_RELU_EN
    if (sum[ACC_W-1]) sum = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      k_reg         <= '0;
      w_addr_reg    <= '0;
      neuron_reg    <= '0;
      lat_reg       <= '0;
      vld_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      out_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      vld_reg   <= vld_next;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            k_reg      <= '0;
            w_addr_reg <= '0;
            neuron_reg <= '0;
          end
        end
        ST_ISSUE: begin
          k_reg      <= (k_reg == K_LAST) ? '0 : k_reg + K_W'(1);
          w_addr_reg <= w_addr_reg + WA_W'(1);
        end
        ST_DRAIN: lat_reg <= (lat_reg == LAT_LAST) ? '0 : lat_reg + 2'd1;
        ST_BIAS: begin
          out_valid_reg <= 1'b1;
          out_idx_reg   <= neuron_reg;
          out_data_reg  <= sum;
        end
        ST_OUT: begin
          if (accept) begin
            out_valid_reg <= 1'b0;
            if (!last_neuron) neuron_reg <= neuron_reg + N_W'(1);
          end
        end
        ST_FIN:  neuron_reg <= '0;
        default: ;
      endcase
    end
  end

  fc_mac u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (mac_clear),
    .en    (mac_en),
    .a     (act_data),
    .b     (w_data),
    .acc   (mac_acc)
  );

  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_FIN);
  assign act_rd_en = (state_reg == ST_ISSUE);
  assign w_rd_en   = (state_reg == ST_ISSUE);
  assign act_addr  = k_reg;
  assign w_addr    = w_addr_reg;
  assign b_addr    = neuron_reg;

  assign out_if.out_valid = out_valid_reg;
  assign out_if.out_idx   = out_idx_reg;
  assign out_if.out_data  = out_data_reg;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq: small RD_LAT=1 and RD_LAT=2 instances on shared RAM models plus a
// full-length (N_IN=3136) instance fed constant extremes; results checked against a dot-product model.
module tb_fc_layer_seq;
  import cnn_fc_pkg::*;

  localparam int NI    = 4;
  localparam int NO    = 2;
  localparam int NI_C  = 3136;
  localparam int KW    = idx_w(NI);
  localparam int WAW   = idx_w(NI * NO);
  localparam int NW    = idx_w(NO);
  localparam int KW_C  = idx_w(NI_C);
  localparam int WAW_C = idx_w(NI_C * NO);

  localparam act_t CMAX = act_t'(536870911);
  localparam wgt_t WNEG = wgt_t'(-256);

  logic clk = 1'b0;
  logic rst;
  logic start_ab;
  logic start_c;
  always #5 clk = ~clk;

  act_t act_mem [NI];
  wgt_t w_mem   [NI*NO];
  wgt_t b_mem   [NO];
  wgt_t b_c     [NO];

  // ---- instance a: RD_LAT = 1
  logic busy_a, done_a, ard_a, wrd_a;
  logic [KW-1:0]  aaddr_a;
  logic [WAW-1:0] waddr_a;
  logic [NW-1:0]  baddr_a;
  act_t adata_a;
  wgt_t wdata_a;
  fc_layer_seq_if #(.IDX_W(NW)) if_a ();

  fc_layer_seq #(.N_IN(NI), .N_OUT(NO), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .start(start_ab), .busy(busy_a), .done(done_a),
    .act_rd_en(ard_a), .act_addr(aaddr_a), .act_data(adata_a),
    .w_rd_en(wrd_a), .w_addr(waddr_a), .w_data(wdata_a),
    .b_addr(baddr_a), .b_data(b_mem[baddr_a]), .out_if(if_a)
  );

  always @(posedge clk) begin
    if (ard_a) adata_a <= act_mem[aaddr_a];
    if (wrd_a) wdata_a <= w_mem[waddr_a];
  end

  // ---- instance b: RD_LAT = 2, same memories, always ready
  logic busy_b, done_b, ard_b, wrd_b;
  logic [KW-1:0]  aaddr_b;
  logic [WAW-1:0] waddr_b;
  logic [NW-1:0]  baddr_b;
  act_t adata_b1, adata_b;
  wgt_t wdata_b1, wdata_b;
  fc_layer_seq_if #(.IDX_W(NW)) if_b ();
  assign if_b.out_ready = 1'b1;

  fc_layer_seq #(.N_IN(NI), .N_OUT(NO), .RD_LAT(2)) u_b (
    .clk(clk), .rst(rst), .start(start_ab), .busy(busy_b), .done(done_b),
    .act_rd_en(ard_b), .act_addr(aaddr_b), .act_data(adata_b),
    .w_rd_en(wrd_b), .w_addr(waddr_b), .w_data(wdata_b),
    .b_addr(baddr_b), .b_data(b_mem[baddr_b]), .out_if(if_b)
  );

  always @(posedge clk) begin
    if (ard_b) adata_b1 <= act_mem[aaddr_b];
    if (wrd_b) wdata_b1 <= w_mem[waddr_b];
    adata_b <= adata_b1;
    wdata_b <= wdata_b1;
  end

  // ---- instance c: full length, constant extreme operands
  logic busy_c, done_c, ard_c, wrd_c;
  logic [KW_C-1:0]  aaddr_c;
  logic [WAW_C-1:0] waddr_c;
  logic [NW-1:0]    baddr_c;
  fc_layer_seq_if #(.IDX_W(NW)) if_c ();
  assign if_c.out_ready = 1'b1;

  fc_layer_seq #(.N_IN(NI_C), .N_OUT(NO), .RD_LAT(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
    .act_rd_en(ard_c), .act_addr(aaddr_c), .act_data(CMAX),
    .w_rd_en(wrd_c), .w_addr(waddr_c), .w_data(WNEG),
    .b_addr(baddr_c), .b_data(b_c[baddr_c]), .out_if(if_c)
  );

  // ---- accepted-result and done monitors
  int   qa_idx [$];
  acc_t qa_dat [$];
  int   qb_idx [$];
  acc_t qb_dat [$];
  int   qc_idx [$];
  acc_t qc_dat [$];
  int   dn_a = 0;
  int   dn_b = 0;
  int   dn_c = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (if_a.out_valid && if_a.out_ready) begin
        qa_idx.push_back(int'(if_a.out_idx));
        qa_dat.push_back(if_a.out_data);
      end
      if (if_b.out_valid && if_b.out_ready) begin
        qb_idx.push_back(int'(if_b.out_idx));
        qb_dat.push_back(if_b.out_data);
      end
      if (if_c.out_valid && if_c.out_ready) begin
        qc_idx.push_back(int'(if_c.out_idx));
        qc_dat.push_back(if_c.out_data);
      end
      if (done_a) dn_a <= dn_a + 1;
      if (done_b) dn_b <= dn_b + 1;
      if (done_c) dn_c <= dn_c + 1;
    end
  end

  // ---- reference model: plain dot product, bias, wrap to ACC_W, optional clamp
  function automatic acc_t relu(input acc_t v);
`ifdef FC_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic acc_t model_ab(input int n);
    longint s = 0;
    for (int k = 0; k < NI; k++) s += longint'(act_mem[k]) * longint'(w_mem[n*NI + k]);
    s += longint'(b_mem[n]);
    return relu(acc_t'(s));
  endfunction

  function automatic acc_t model_c(input int n);
    longint s;
    s = longint'(NI_C) * longint'(CMAX) * longint'(WNEG) + longint'(b_c[n]);
    return relu(acc_t'(s));
  endfunction

  // ---- checking
  int n_chk  = 0;
  int n_pass = 0;
  int pass_no = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_pass(input string who, input int base, input int idx_q[$],
                            input acc_t dat_q[$], input bit is_c);
    acc_t exp;
    check_eq({who, "_result_count"}, longint'(dat_q.size() - base), NO);
    for (int n = 0; n < NO; n++) begin
      if (base + n < dat_q.size()) begin
        exp = is_c ? model_c(n) : model_ab(n);
        $display("%s pass %0d: idx %0d data %0d (model %0d)", who, pass_no, idx_q[base+n],
                 dat_q[base+n], exp);
        check_eq({who, "_idx"}, idx_q[base+n], n);
        check_eq({who, "_data"}, dat_q[base+n], exp);
      end
    end
  endtask

  task automatic load_directed(input int b1);
    for (int k = 0; k < NI; k++) begin
      act_mem[k]    = act_t'(k + 1);
      w_mem[k]      = wgt_t'(1);
    end
    w_mem[NI+0] = wgt_t'(-1);
    w_mem[NI+1] = wgt_t'(2);
    w_mem[NI+2] = wgt_t'(0);
    w_mem[NI+3] = wgt_t'(3);
    b_mem[0]    = wgt_t'(5);
    b_mem[1]    = wgt_t'(b1);
  endtask

  task automatic load_random();
    for (int k = 0; k < NI; k++) act_mem[k] = act_t'($urandom);
    for (int k = 0; k < NI*NO; k++) w_mem[k] = wgt_t'($urandom);
    for (int n = 0; n < NO; n++) b_mem[n] = wgt_t'($urandom);
  endtask

  // One full pass on instances a and b together; a may be stalled on neuron 0 and may see a
  // spurious start while busy.
  task automatic run_pass(input int stall, input bit poke);
    int  base_a, base_b, d_a, d_b, stall_left, first_rd, first_vld;
    bit  seen_done;
    pass_no++;
    base_a = qa_dat.size();
    base_b = qb_dat.size();
    d_a = dn_a;
    d_b = dn_b;
    stall_left = stall;
    first_rd = -1;
    first_vld = -1;
    seen_done = 1'b0;
    @(negedge clk);
    start_ab = 1'b1;
    @(negedge clk);
    start_ab = 1'b0;
    check_eq("busy_after_start", busy_a, 1);
    for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      start_ab = poke && (cyc == 3);
      if (ard_a && first_rd < 0) first_rd = cyc;
      if (if_a.out_valid && first_vld < 0) first_vld = cyc;
      if (if_a.out_valid && if_a.out_idx == 0 && stall_left > 0) begin
        if_a.out_ready = 1'b0;
        check_eq("stall_no_read", {ard_a, wrd_a}, 0);
        check_eq("stall_hold_data", if_a.out_data, model_ab(0));
        stall_left--;
      end else begin
        if_a.out_ready = 1'b1;
      end
      if (done_a) seen_done = 1'b1;
      @(negedge clk);
    end
    start_ab = 1'b0;
    if_a.out_ready = 1'b1;
    check_eq("a_done_seen", seen_done, 1);
    if (stall == 0) check_eq("a_latency", first_vld - first_rd + 1, NI + 1 + 2);
    for (int w = 0; w < 50 && dn_b == d_b; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("a_done_once", dn_a - d_a, 1);
    check_eq("b_done_once", dn_b - d_b, 1);
    check_eq("a_idle_after", {busy_a, done_a}, 0);
    check_pass("a", base_a, qa_idx, qa_dat, 1'b0);
    check_pass("b", base_b, qb_idx, qb_dat, 1'b0);
  endtask

  initial begin
    int  base, d;
    bit  found;

    // reset with start held high: reset must win
    rst = 1'b1;
    start_ab = 1'b1;
    start_c = 1'b1;
    if_a.out_ready = 1'b1;
    for (int n = 0; n < NO; n++) b_c[n] = wgt_t'($urandom);
    load_directed(-7);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    start_ab = 1'b0;
    start_c = 1'b0;
    check_eq("reset_ctrl_a", {busy_a, done_a, ard_a, wrd_a, if_a.out_valid}, 0);
    check_eq("reset_addr_a", {aaddr_a, waddr_a, baddr_a, if_a.out_idx}, 0);
    check_eq("reset_data_a", if_a.out_data, 0);
    check_eq("reset_busy_bc", {busy_b, busy_c}, 0);
    @(negedge clk);
    check_eq("idle_after_reset", busy_a, 0);

    // directed dot products
    base = qa_dat.size();
    run_pass(0, 1'b0);
    if (qa_dat.size() >= base + 2) begin
      check_eq("directed_idx0", qa_dat[base], 15);
      check_eq("directed_idx1", qa_dat[base+1], 8);
    end else begin
      check_eq("directed_count", qa_dat.size() - base, 2);
    end

    // consumer stall on neuron 0, then spurious start while busy
    run_pass(5, 1'b0);
    run_pass(0, 1'b1);

    // negative bias: clamped only when the rectifier is built in
    load_directed(-20);
    run_pass(0, 1'b0);

    // reset in the middle of neuron 1's read phase
    load_directed(-7);
    base = qa_dat.size();
    d = dn_a;
    @(negedge clk);
    start_ab = 1'b1;
    @(negedge clk);
    start_ab = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 60 && !found; cyc++) begin
      if (ard_a && baddr_a == 1 && aaddr_a == 1) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("mid_issue_reached", found, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_ctrl_a", {busy_a, done_a, ard_a, wrd_a, if_a.out_valid}, 0);
    check_eq("abort_addr_a", {aaddr_a, waddr_a, baddr_a, if_a.out_idx}, 0);
    check_eq("abort_data_a", if_a.out_data, 0);
    repeat (20) @(negedge clk);
    check_eq("abort_results", qa_dat.size() - base, 1);
    check_eq("abort_no_done", dn_a - d, 0);
    run_pass(0, 1'b0);

    // randomized passes
    for (int r = 0; r < 6; r++) begin
      load_random();
      run_pass($urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // full-length accumulation with extreme operands
    base = qc_dat.size();
    d = dn_c;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int w = 0; w < 8000 && dn_c == d; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("c_done_once", dn_c - d, 1);
    check_pass("c", base, qc_idx, qc_dat, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
